// File: rtl/mimc_cipher_iter.sv
// mimc_cipher_iter: iterative MiMC-7 block cipher with optional Miyaguchi-Preneel feed-forward.
// Ports: clk/rst (async active-low); in_valid/in_ready/in_data/in_key/in_mode input handshake;
// rc_addr/rc_data combinational round-constant ROM; out_valid/out_ready/out_data output handshake;
// busy high whenever not IDLE.
module mimc_cipher_iter #(
  parameter int N_BITS = 254,
  parameter logic [N_BITS-1:0] PRIME = N_BITS'(254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001),
  parameter int N_ROUNDS = 91,
  parameter int RC_AW = N_ROUNDS > 1 ? $clog2(N_ROUNDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  input  logic [N_BITS-1:0] in_key,
  input  logic              in_mode,
  output logic [RC_AW-1:0]  rc_addr,
  input  logic [N_BITS-1:0] rc_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_data,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, ADD, MUL, FINAL, OUT} state_t;
  localparam int EW = N_BITS + 2;
  localparam int BW = N_BITS > 1 ? $clog2(N_BITS) : 1;
  localparam logic [EW-1:0] P_E = EW'(PRIME);
  localparam logic [RC_AW-1:0] LAST = RC_AW'(N_ROUNDS - 1);
  localparam logic [BW-1:0] TOP = BW'(N_BITS - 1);
  // Any sum below 3*PRIME is brought into range by two conditional subtractions.
  function automatic logic [N_BITS-1:0] red(input logic [EW-1:0] s);
    logic [EW-1:0] r;
    r = s >= P_E ? s - P_E : s;
    r = r >= P_E ? r - P_E : r;
    return r[N_BITS-1:0];
  endfunction
  state_t state, state_n;
  logic [N_BITS-1:0] x, k, x_in, t, p, acc;
  logic [N_BITS-1:0] mul_a, mul_b, acc_n, add_t, fin;
  logic mode, last_bit;
  logic [1:0] op;
  logic [BW-1:0] bit_idx;
  logic [RC_AW-1:0] round;
  // Operand routing for t2=t*t, t3=t2*t, t6=t3*t3, x=t6*t; p holds the previous product.
  always_comb begin
    mul_a = op == 2'd0 ? t : p;
    mul_b = op == 2'd2 ? p : t;
    acc_n = red({1'b0, acc, 1'b0} + (mul_b[bit_idx] ? EW'(mul_a) : '0));
    add_t = red(EW'(x) + EW'(k) + EW'(rc_data));
    fin = red(EW'(x) + EW'(k) + (mode ? EW'(x_in) : '0));
    last_bit = bit_idx == '0;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_valid ? ADD : IDLE;
      ADD:     state_n = MUL;
      MUL:     state_n = (last_bit && op == 2'd3) ? (round == LAST ? FINAL : ADD) : MUL;
      FINAL:   state_n = OUT;
      OUT:     state_n = out_ready ? IDLE : OUT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      k <= '0;
      x_in <= '0;
      mode <= 1'b0;
      t <= '0;
      p <= '0;
      acc <= '0;
      op <= '0;
      bit_idx <= '0;
      round <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x <= in_data;
          k <= in_key;
          x_in <= in_data;
          mode <= in_mode;
          round <= '0;
        end
        ADD: begin
          t <= add_t;
          acc <= '0;
          op <= '0;
          bit_idx <= TOP;
        end
        MUL: if (last_bit) begin
          p <= acc_n;
          acc <= '0;
          op <= op + 2'd1;
          bit_idx <= TOP;
          if (op == 2'd3) begin
            x <= acc_n;
            round <= round == LAST ? round : round + 1'b1;
          end
        end else begin
          acc <= acc_n;
          bit_idx <= bit_idx - 1'b1;
        end
        FINAL: out_data <= fin;
        default: ;
      endcase
    end
  end
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == OUT;
  assign rc_addr = round;
endmodule

// File: tb/tb_mimc_cipher_iter.sv
// tb_mimc_cipher_iter: randomized and directed checks of mimc_cipher_iter against a field-arithmetic model.
module tb_mimc_cipher_iter;
  localparam int P = 251;
  localparam int LAT = 67;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_mode, out_valid, out_ready, busy;
  logic [7:0] in_data, in_key, rc_data, out_data;
  logic [0:0] rc_addr;
  logic [7:0] c [2];
  int vectors = 0;
  int miscompares = 0;
  int exp_q = 0;
  mimc_cipher_iter #(.N_BITS(8), .PRIME(8'd251), .N_ROUNDS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_key(in_key), .in_mode(in_mode), .rc_addr(rc_addr), .rc_data(rc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  assign rc_data = c[rc_addr];
  always #5 clk = ~clk;
  function automatic void check(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endfunction
  function automatic int pow7(int b);
    int r = 1;
    for (int i = 0; i < 7; i++) r = (r * b) % P;
    return r;
  endfunction
  function automatic int mimc(int xv, int kv, int c0, int c1, int m);
    int v = xv;
    v = pow7((v + kv + c0) % P);
    v = pow7((v + kv + c1) % P);
    return (v + kv + (m != 0 ? xv : 0)) % P;
  endfunction
  always @(negedge clk) if (rst && out_valid) check("out_data", int'(out_data), exp_q);
  task automatic start(input int xv, input int kv, input int c0, input int c1, input int m);
    int w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_wait", int'(in_ready), 1);
    c[0] = 8'(c0);
    c[1] = 8'(c1);
    in_data = 8'(xv);
    in_key = 8'(kv);
    in_mode = m[0];
    in_valid = 1'b1;
    exp_q = mimc(xv, kv, c0, c1, m);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic finish(input int lit, input int hold);
    int n = 0;
    int rc0, rc1 = 0;
    bit bz = 1'b1;
    bit st = 1'b1;
    out_ready = hold == 0;
    rc0 = int'(rc_addr);
    while (!out_valid && n < 200) begin
      if (n == 33) rc1 = int'(rc_addr);
      if (in_ready || !busy) bz = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    check("latency", n, LAT);
    check("busy_during_run", int'(bz), 1);
    check("rc_addr_round0", rc0, 0);
    check("rc_addr_round1", rc1, 1);
    if (lit >= 0) check("literal_result", int'(out_data), lit);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      @(posedge clk); #1;
      if (!out_valid || int'(out_data) != exp_q || in_ready || !busy) st = 1'b0;
    end
    in_valid = 1'b0;
    check("backpressure_hold", int'(st), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handshake_idle", int'({out_valid, in_ready, busy}), 3'b010);
  endtask
  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_key = '0;
    in_mode = 1'b0;
    out_ready = 1'b1;
    c[0] = '0;
    c[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", int'({out_valid, in_ready, busy}), 3'b010);
    check("reset_out_data", int'(out_data), 0);
    check("reset_rc_addr", int'(rc_addr), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    start(2, 0, 0, 0, 0);   finish(126, 0);
    start(2, 0, 0, 0, 1);   finish(128, 0);
    start(1, 3, 5, 0, 0);   finish(132, 0);
    start(250, 1, 0, 0, 0); finish(2, 0);
    start(0, 0, 0, 0, 0);   finish(0, 0);
    start(2, 0, 0, 0, 0);   finish(126, 10);
    start(1, 3, 5, 0, 0);   finish(132, 0);
    start(2, 0, 0, 0, 0);
    repeat (40) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_reset_flags", int'({out_valid, in_ready, busy}), 3'b010);
    check("async_reset_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    start(2, 0, 0, 0, 0);   finish(126, 0);
    for (int i = 0; i < 16; i++) begin
      start($urandom_range(0, P - 1), $urandom_range(0, P - 1), $urandom_range(0, P - 1),
            $urandom_range(0, P - 1), $urandom_range(0, 1));
      finish(-1, $urandom_range(0, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
